// File: rtl/i2c_slave_receiver.sv
// I2C target receiver: oversamples scl/sda on the system clock, detects
// START/STOP, matches a 7-bit write address, ACKs each accepted byte and
// hands received data bytes to the consumer on a one-cycle strobe.
// Reads are NACKed and ignored; there is no transmit path.
module i2c_slave_receiver #(
  parameter logic [6:0] ADDRESS     = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addressed,
  output logic       stop_seen,
  output logic       overflow
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  // Synchroniser chains plus one registered copy used for edge detection.
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;

  logic scl_s;
  logic sda_s;
  logic scl_rise;
  logic scl_fall;
  logic sda_rise;
  logic sda_fall;
  logic start_det;
  logic stop_det;

  state_t     state;
  logic [3:0] bit_cnt;
  logic [6:0] shift_reg;
  logic       ack_phase;
  logic       ack_pending;
  logic       sda_drive;
  logic [7:0] received_byte;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign sda_rise = sda_s & ~sda_q;
  assign sda_fall = ~sda_s & sda_q;

  // scl must be high in both samples so an sda edge that coincides with an
  // scl edge is never mistaken for a bus condition.
  assign start_det = sda_fall & scl_s & scl_q;
  assign stop_det  = sda_rise & scl_s & scl_q;

  // The bit currently on the wire completes the byte held in shift_reg.
  assign received_byte = {shift_reg, sda_s};

  // Open-drain output; reset releases the line immediately, not a cycle later.
  assign sda = (sda_drive && !reset) ? 1'b0 : 1'bz;

  // Bring scl/sda into the clock domain and keep the previous sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  // Protocol state machine; bus conditions take priority over scl edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shift_reg   <= 7'd0;
      ack_phase   <= 1'b0;
      ack_pending <= 1'b0;
      sda_drive   <= 1'b0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      addressed   <= 1'b0;
      stop_seen   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      stop_seen <= 1'b0;

      if (start_det) begin
        state       <= ADDR;
        bit_cnt     <= 4'd0;
        ack_phase   <= 1'b0;
        ack_pending <= 1'b0;
        sda_drive   <= 1'b0;
        addressed   <= 1'b0;
        overflow    <= 1'b0;
      end else if (stop_det) begin
        if (state != IDLE) begin
          state     <= IDLE;
          bit_cnt   <= 4'd0;
          ack_phase <= 1'b0;
          sda_drive <= 1'b0;
          addressed <= 1'b0;
          stop_seen <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            sda_drive <= 1'b0;
          end

          ADDR: begin
            if (scl_rise) begin
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
                if ((received_byte[7:1] == ADDRESS) && !received_byte[0]) begin
                  state <= ADDR_ACK;
                end else begin
                  state <= IGNORE;
                end
              end else begin
                shift_reg <= received_byte[6:0];
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_drive <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                sda_drive <= 1'b0;
                ack_phase <= 1'b0;
                addressed <= 1'b1;
                state     <= DATA;
              end
            end
          end

          DATA: begin
            if (scl_rise) begin
              if (bit_cnt == 4'd7) begin
                bit_cnt   <= 4'd0;
                ack_phase <= 1'b0;
                state     <= DATA_ACK;
                if (rx_ready) begin
                  rx_data     <= received_byte;
                  rx_valid    <= 1'b1;
                  ack_pending <= 1'b1;
                end else begin
                  overflow    <= 1'b1;
                  ack_pending <= 1'b0;
                end
              end else begin
                shift_reg <= received_byte[6:0];
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end

          DATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_drive <= ack_pending;
                ack_phase <= 1'b1;
              end else begin
                sda_drive <= 1'b0;
                ack_phase <= 1'b0;
                state     <= DATA;
              end
            end
          end

          IGNORE: begin
            sda_drive <= 1'b0;
          end

          default: begin
            state     <= IDLE;
            sda_drive <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Directed testbench for i2c_slave_receiver: a behavioural bus master drives
// scl/sda, a monitor logs strobes and target drive, and each scenario task
// compares observed behaviour against hand-computed expectations.
module tb_i2c_slave_receiver;

  localparam int Q = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_low;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addressed;
  logic       stop_seen;
  logic       overflow;
  wire        sda_line;

  int vectors = 0;
  int miscompares = 0;
  int valid_cnt = 0;
  int stop_cnt = 0;
  int drive_cnt = 0;
  logic [7:0] got[$];

  pullup (sda_line);
  assign sda_line = m_low ? 1'b0 : 1'bz;

  i2c_slave_receiver #(
    .ADDRESS(7'h50),
    .SYNC_STAGES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .scl(scl),
    .sda(sda_line),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .addressed(addressed),
    .stop_seen(stop_seen),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Log strobes and any cycle where the target holds sda low.
  always @(posedge clock) begin
    if (rx_valid) begin
      valid_cnt++;
      got.push_back(rx_data);
    end
    if (stop_seen) stop_cnt++;
    if (!m_low && sda_line === 1'b0) drive_cnt++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    wait_cycles(Q);
    scl = 1'b1;
    wait_cycles(Q);
    m_low = 1'b1;
    wait_cycles(Q);
    scl = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    wait_cycles(Q);
    scl = 1'b1;
    wait_cycles(Q);
    m_low = 1'b0;
    wait_cycles(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b;
    wait_cycles(Q);
    scl = 1'b1;
    wait_cycles(2 * Q);
    scl = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
  endtask

  task automatic read_ack(output logic a);
    m_low = 1'b0;
    wait_cycles(Q);
    scl = 1'b1;
    wait_cycles(Q);
    a = sda_line;
    wait_cycles(Q);
    scl = 1'b0;
    wait_cycles(Q);
  endtask

  task automatic test_reset();
    wait_cycles(3);
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    vectors++; if (addressed !== 1'b0) begin miscompares++; $display("FAIL reset_addressed got=%b exp=0", addressed); end
    vectors++; if (stop_seen !== 1'b0) begin miscompares++; $display("FAIL reset_stop_seen got=%b exp=0", stop_seen); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    vectors++; if (sda_line !== 1'b1) begin miscompares++; $display("FAIL reset_sda got=%b exp=1", sda_line); end
  endtask

  task automatic test_single_write();
    logic a;
    logic [7:0] b0;
    int v0, s0;
    got.delete();
    v0 = valid_cnt; s0 = stop_cnt;
    i2c_start();
    write_byte(8'hA0);
    vectors++; if (addressed !== 1'b0) begin miscompares++; $display("FAIL t1_addressed_before_ack got=%b exp=0", addressed); end
    read_ack(a);
    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL t1_addr_ack got=%b exp=0", a); end
    vectors++; if (addressed !== 1'b1) begin miscompares++; $display("FAIL t1_addressed_after_ack got=%b exp=1", addressed); end
    write_byte(8'hA5);
    read_ack(a);
    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL t1_data_ack got=%b exp=0", a); end
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL t1_valid_count got=%0d exp=1", valid_cnt - v0); end
    b0 = (got.size() > 0) ? got[0] : 8'hxx;
    vectors++; if (b0 !== 8'hA5) begin miscompares++; $display("FAIL t1_byte got=%h exp=a5", b0); end
    vectors++; if (rx_data !== 8'hA5) begin miscompares++; $display("FAIL t1_rx_data got=%h exp=a5", rx_data); end
    i2c_stop();
    vectors++; if (stop_cnt - s0 !== 1) begin miscompares++; $display("FAIL t1_stop_count got=%0d exp=1", stop_cnt - s0); end
    vectors++; if (addressed !== 1'b0) begin miscompares++; $display("FAIL t1_addressed_after_stop got=%b exp=0", addressed); end
  endtask

  task automatic test_wrong_address();
    logic a;
    int v0, d0;
    v0 = valid_cnt; d0 = drive_cnt;
    i2c_start();
    write_byte(8'hA2);
    read_ack(a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL t2_addr_nack got=%b exp=1", a); end
    vectors++; if (addressed !== 1'b0) begin miscompares++; $display("FAIL t2_addressed got=%b exp=0", addressed); end
    write_byte(8'h55);
    read_ack(a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL t2_data_nack got=%b exp=1", a); end
    vectors++; if (addressed !== 1'b0) begin miscompares++; $display("FAIL t2_addressed_late got=%b exp=0", addressed); end
    i2c_stop();
    vectors++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL t2_valid_count got=%0d exp=0", valid_cnt - v0); end
    vectors++; if (drive_cnt - d0 !== 0) begin miscompares++; $display("FAIL t2_drive_cycles got=%0d exp=0", drive_cnt - d0); end
  endtask

  task automatic test_read_ignored();
    logic a;
    int v0, d0, s0;
    v0 = valid_cnt; d0 = drive_cnt; s0 = stop_cnt;
    i2c_start();
    write_byte(8'hA1);
    read_ack(a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL t3_read_nack got=%b exp=1", a); end
    write_byte(8'hC3);
    read_ack(a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL t3_data_nack got=%b exp=1", a); end
    i2c_stop();
    vectors++; if (drive_cnt - d0 !== 0) begin miscompares++; $display("FAIL t3_drive_cycles got=%0d exp=0", drive_cnt - d0); end
    vectors++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL t3_valid_count got=%0d exp=0", valid_cnt - v0); end
    vectors++; if (stop_cnt - s0 !== 1) begin miscompares++; $display("FAIL t3_stop_count got=%0d exp=1", stop_cnt - s0); end
  endtask

  task automatic test_overflow();
    logic a;
    logic [7:0] b0, b1;
    int v0;
    got.delete();
    v0 = valid_cnt;
    i2c_start();
    write_byte(8'hA0);
    read_ack(a);
    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL t4_addr_ack got=%b exp=0", a); end
    write_byte(8'h01);
    read_ack(a);
    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL t4_ack1 got=%b exp=0", a); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t4_overflow_early got=%b exp=0", overflow); end
    rx_ready = 1'b0;
    write_byte(8'h02);
    read_ack(a);
    rx_ready = 1'b1;
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL t4_ack2 got=%b exp=1", a); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t4_overflow_set got=%b exp=1", overflow); end
    write_byte(8'h03);
    read_ack(a);
    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL t4_ack3 got=%b exp=0", a); end
    i2c_stop();
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t4_overflow_sticky got=%b exp=1", overflow); end
    vectors++; if (valid_cnt - v0 !== 2) begin miscompares++; $display("FAIL t4_valid_count got=%0d exp=2", valid_cnt - v0); end
    b0 = (got.size() > 0) ? got[0] : 8'hxx;
    b1 = (got.size() > 1) ? got[1] : 8'hxx;
    vectors++; if (b0 !== 8'h01) begin miscompares++; $display("FAIL t4_byte0 got=%h exp=01", b0); end
    vectors++; if (b1 !== 8'h03) begin miscompares++; $display("FAIL t4_byte1 got=%h exp=03", b1); end
  endtask

  task automatic test_repeated_start();
    logic a;
    logic [7:0] b0;
    int v0;
    i2c_start();
    write_byte(8'hA0);
    read_ack(a);
    rx_ready = 1'b0;
    write_byte(8'h77);
    read_ack(a);
    rx_ready = 1'b1;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL t5_overflow_pre got=%b exp=1", overflow); end
    got.delete();
    v0 = valid_cnt;
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    i2c_start();
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t5_overflow_cleared got=%b exp=0", overflow); end
    vectors++; if (addressed !== 1'b0) begin miscompares++; $display("FAIL t5_addressed_cleared got=%b exp=0", addressed); end
    write_byte(8'hA0);
    read_ack(a);
    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL t5_addr_ack got=%b exp=0", a); end
    write_byte(8'h3C);
    read_ack(a);
    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL t5_data_ack got=%b exp=0", a); end
    i2c_stop();
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL t5_valid_count got=%0d exp=1", valid_cnt - v0); end
    b0 = (got.size() > 0) ? got[0] : 8'hxx;
    vectors++; if (b0 !== 8'h3C) begin miscompares++; $display("FAIL t5_byte got=%h exp=3c", b0); end
  endtask

  task automatic test_reset_mid_ack();
    logic a;
    logic [7:0] b0;
    int v0, d0, s0;
    i2c_start();
    write_byte(8'hA0);
    m_low = 1'b0;
    wait_cycles(1);
    vectors++; if (sda_line !== 1'b0) begin miscompares++; $display("FAIL t6_ack_driven got=%b exp=0", sda_line); end
    reset = 1'b1;
    wait_cycles(1);
    vectors++; if (sda_line !== 1'b1) begin miscompares++; $display("FAIL t6_sda_released got=%b exp=1", sda_line); end
    vectors++; if (addressed !== 1'b0) begin miscompares++; $display("FAIL t6_addressed got=%b exp=0", addressed); end
    vectors++; if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL t6_rx_valid got=%b exp=0", rx_valid); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL t6_overflow got=%b exp=0", overflow); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL t6_rx_data got=%h exp=00", rx_data); end
    reset = 1'b0;
    v0 = valid_cnt; d0 = drive_cnt; s0 = stop_cnt;
    wait_cycles(Q - 1);
    scl = 1'b1;
    wait_cycles(Q);
    a = sda_line;
    wait_cycles(Q);
    scl = 1'b0;
    wait_cycles(Q);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL t6_ninth_bit got=%b exp=1", a); end
    write_byte(8'hA0);
    read_ack(a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL t6_no_ack_without_start got=%b exp=1", a); end
    i2c_stop();
    vectors++; if (drive_cnt - d0 !== 0) begin miscompares++; $display("FAIL t6_drive_cycles got=%0d exp=0", drive_cnt - d0); end
    vectors++; if (stop_cnt - s0 !== 0) begin miscompares++; $display("FAIL t6_idle_stop got=%0d exp=0", stop_cnt - s0); end
    got.delete();
    i2c_start();
    write_byte(8'hA0);
    read_ack(a);
    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL t6_resume_ack got=%b exp=0", a); end
    write_byte(8'h99);
    read_ack(a);
    i2c_stop();
    b0 = (got.size() > 0) ? got[0] : 8'hxx;
    vectors++; if (b0 !== 8'h99) begin miscompares++; $display("FAIL t6_resume_byte got=%h exp=99", b0); end
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL t6_valid_count got=%0d exp=1", valid_cnt - v0); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    reset = 1'b1;
    scl = 1'b1;
    m_low = 1'b0;
    rx_ready = 1'b1;
    test_reset();
    reset = 1'b0;
    wait_cycles(10);
    test_single_write();
    test_wrong_address();
    test_read_ignored();
    test_overflow();
    test_repeated_start();
    test_reset_mid_ack();
    wait_cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
